// File: rtl/riscv_test_monitor_pkg.sv
// Shared definitions for the end-of-test monitor: FSM state encoding, the
// riscv-tests pass value of gp, and the state-to-verdict-flag decode.
package riscv_test_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN     = 3'd1,
      ST_PASS    = 3'd2,
      ST_FAIL    = 3'd3,
      ST_TIMEOUT = 3'd4,
      ST_HANG    = 3'd5
   } state_t;

   localparam int PASS_GP = 1;

   // Flag order: {done, pass, fail, timeout, hang}
   function automatic logic [4:0] verdict_flags(input state_t s);
      logic [4:0] f;
      f = 5'b00000;
      case (s)
         ST_PASS:    f = 5'b11000;
         ST_FAIL:    f = 5'b10100;
         ST_TIMEOUT: f = 5'b10010;
         ST_HANG:    f = 5'b10001;
         default:    f = 5'b00000;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/riscv_test_monitor_if.sv
// Core-to-monitor bundle: the core drives exit/gp/pc, the monitor returns
// its sticky verdict, frozen cycle count and FSM state.
interface riscv_test_monitor_if #(
   parameter int GP_W  = 3,
   parameter int CNT_W = 16
);
   logic             exit;
   logic [GP_W-1:0]  gp;
   logic [31:0]      pc;

   logic             done;
   logic             pass;
   logic             fail;
   logic             timeout;
   logic             hang;
   logic [GP_W-2:0]  fail_test;
   logic [CNT_W-1:0] cycle_cnt;
   logic [2:0]       state;

   modport master (
      output exit, gp, pc,
      input  done, pass, fail, timeout, hang, fail_test, cycle_cnt, state
   );

   modport slave (
      input  exit, gp, pc,
      output done, pass, fail, timeout, hang, fail_test, cycle_cnt, state
   );
endinterface

// File: rtl/riscv_test_monitor_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over
// increment.
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (clr) begin
         q <= '0;
      end else if (en && (q != {WIDTH{1'b1}})) begin
         q <= q + WIDTH'(1);
      end
   end

endmodule

// File: rtl/riscv_test_monitor.sv
// End-of-test checker: watches exit/gp/pc from the core and latches a sticky
// PASS/FAIL/TIMEOUT/HANG verdict plus the number of RUN cycles it took.
module riscv_test_monitor
   import riscv_test_pkg::*;
#(
   parameter int GP_W        = 3,
   parameter int CNT_W       = 16,
   parameter int TIMEOUT_CYC = 4096,
   parameter int HANG_CYC    = 64
) (
   input  logic               clk,
   input  logic               rst,
   riscv_test_monitor_if.slave bus
);

   localparam int HANG_W = $clog2(HANG_CYC + 1);

   state_t            state_q;
   state_t            state_d;
   logic [31:0]       pc_q;
   logic [CNT_W-1:0]  cycle_cnt;
   logic [HANG_W-1:0] hang_cnt;
   logic [4:0]        flags_q;
   logic [GP_W-2:0]   fail_test_q;

   logic in_run;
   logic pc_same;
   logic hang_hit;
   logic timeout_hit;
   logic gp_pass;

   assign in_run      = (state_q == ST_RUN);
   assign pc_same     = (bus.pc == pc_q);
   assign hang_hit    = pc_same && (hang_cnt == HANG_W'(HANG_CYC - 1));
   assign timeout_hit = (cycle_cnt == CNT_W'(TIMEOUT_CYC - 1));
   assign gp_pass     = (bus.gp == GP_W'(PASS_GP));

   // Counters only advance in RUN, so they freeze once a verdict is taken.
   sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
      .clk (clk),
      .clr (rst),
      .en  (in_run),
      .q   (cycle_cnt)
   );

   sat_counter #(.WIDTH(HANG_W)) u_hang_cnt (
      .clk (clk),
      .clr (rst || (in_run && !pc_same)),
      .en  (in_run && pc_same),
      .q   (hang_cnt)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: state_d = ST_RUN;
         ST_RUN: begin
            if (bus.exit) begin
               state_d = gp_pass ? ST_PASS : ST_FAIL;
            end else if (hang_hit) begin
               state_d = ST_HANG;
            end else if (timeout_hit) begin
               state_d = ST_TIMEOUT;
            end
         end
         ST_PASS, ST_FAIL, ST_TIMEOUT, ST_HANG: state_d = state_q;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pc_q        <= '0;
         flags_q     <= '0;
         fail_test_q <= '0;
      end else begin
         state_q <= state_d;
         flags_q <= verdict_flags(state_d);
         if (in_run) begin
            pc_q <= bus.pc;
         end
         // gp==0 falls out as fail id 0, which is what a protocol error reports.
         if (in_run && (state_d == ST_FAIL)) begin
            fail_test_q <= bus.gp[GP_W-1:1];
         end
      end
   end

   assign bus.done      = flags_q[4];
   assign bus.pass      = flags_q[3];
   assign bus.fail      = flags_q[2];
   assign bus.timeout   = flags_q[1];
   assign bus.hang      = flags_q[0];
   assign bus.fail_test = fail_test_q;
   assign bus.cycle_cnt = cycle_cnt;
   assign bus.state     = state_q;

endmodule
